mc_ctrl_unit: RTL and testbench

- Multi-cycle control unit for the RISC-V core; replaces the single-cycle combinational decoder.
- FSM sequences fetch/decode/execute/memory/writeback over a shared datapath.
- Adds memory ready handshakes, a timeout-to-trap, illegal-opcode trap, BNE and JAL/LUI support, and a retired-instruction counter.

---
 rtl/mc_cu_pkg.sv | 45 ++++
 rtl/mc_cu_decode.sv | 51 +++++
 rtl/mc_ctrl_unit.sv | 171 +++++++++++++++++
 tb/tb_mc_ctrl_unit.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mc_cu_pkg.sv
// Shared encodings for the multi-cycle control unit: opcodes, FSM states,
// instruction classes and datapath select codes.
package mc_cu_pkg;

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_LD  = 7'b0000011;
  localparam logic [6:0] OP_ST  = 7'b0100011;
  localparam logic [6:0] OP_BR  = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_LUI = 7'b0110111;

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4,
    TRAP   = 3'd5
  } state_t;

  typedef enum logic [2:0] {
    CLS_R, CLS_I, CLS_LD, CLS_ST, CLS_BR, CLS_JAL, CLS_LUI, CLS_ILLEGAL
  } iclass_t;

  localparam logic [1:0] PC_PLUS4  = 2'd0;
  localparam logic [1:0] PC_BRANCH = 2'd1;
  localparam logic [1:0] PC_JAL    = 2'd2;

  localparam logic [1:0] WB_ALU = 2'd0;
  localparam logic [1:0] WB_MEM = 2'd1;
  localparam logic [1:0] WB_PC4 = 2'd2;

  localparam logic [2:0] IMM_I = 3'd0;
  localparam logic [2:0] IMM_S = 3'd1;
  localparam logic [2:0] IMM_B = 3'd2;
  localparam logic [2:0] IMM_J = 3'd3;
  localparam logic [2:0] IMM_U = 3'd4;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_BR    = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;
  localparam logic [1:0] ALU_PASSB = 2'b11;

endpackage

// File: rtl/mc_cu_decode.sv
// Combinational instruction classifier: opcode/funct3 to instruction class,
// branch flavour and immediate format.
module mc_cu_decode
  import mc_cu_pkg::*;
#(
  parameter int EN_JAL = 1
) (
  input  logic [31:0] instr,
  output iclass_t     iclass,
  output logic        is_bne,
  output logic [2:0]  imm_ctrl
);

  logic unused_bits;
  assign unused_bits = ^{instr[31:15], instr[11:7]};

  always_comb begin
    iclass   = CLS_ILLEGAL;
    is_bne   = 1'b0;
    imm_ctrl = IMM_I;
    case (instr[6:0])
      OP_R:   iclass = CLS_R;
      OP_I:   iclass = CLS_I;
      OP_LD:  iclass = CLS_LD;
      OP_ST: begin
        iclass   = CLS_ST;
        imm_ctrl = IMM_S;
      end
      OP_BR: begin
        imm_ctrl = IMM_B;
        // only BEQ and BNE are implemented; other compares trap
        if (instr[14:12] == 3'b000) begin
          iclass = CLS_BR;
        end else if (instr[14:12] == 3'b001) begin
          iclass = CLS_BR;
          is_bne = 1'b1;
        end
      end
      OP_JAL: begin
        imm_ctrl = IMM_J;
        if (EN_JAL != 0) iclass = CLS_JAL;
      end
      OP_LUI: begin
        iclass   = CLS_LUI;
        imm_ctrl = IMM_U;
      end
      default: iclass = CLS_ILLEGAL;
    endcase
  end

endmodule

// File: rtl/mc_ctrl_unit.sv
// Multi-cycle RISC-V control FSM with memory ready handshakes, wait timeout
// trap, illegal-instruction trap and a retired-instruction counter.
module mc_ctrl_unit
  import mc_cu_pkg::*;
#(
  parameter int CNT_W   = 32,
  parameter int TIMEOUT = 16,
  parameter int EN_JAL  = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [31:0]      instr,
  input  logic             alu_zero,
  input  logic             imem_ready,
  input  logic             dmem_ready,
  output logic             imem_req,
  output logic             dmem_req,
  output logic             dmem_we,
  output logic             ir_we,
  output logic             pc_we,
  output logic [1:0]       pc_src,
  output logic             alu_src_b,
  output logic [1:0]       alu_ctrl_op,
  output logic [2:0]       imm_ctrl,
  output logic             reg_we,
  output logic [1:0]       wb_sel,
  output logic             trap,
  output logic [CNT_W-1:0] instret,
  output logic [2:0]       state
);

  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  state_t        cur, nxt;
  iclass_t       iclass;
  logic          is_bne;
  logic [2:0]    dec_imm;
  logic [TW-1:0] tmo_cnt, tmo_nxt;
  logic          tmo_hit;
  logic          retire;

  mc_cu_decode #(.EN_JAL(EN_JAL)) u_decode (
    .instr    (instr),
    .iclass   (iclass),
    .is_bne   (is_bne),
    .imm_ctrl (dec_imm)
  );

  // the wait that would push the count to TIMEOUT is the last one allowed
  assign tmo_hit = (TIMEOUT > 0) && (tmo_cnt == TW'(TIMEOUT - 1));
  assign state   = cur;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur     <= FETCH;
      tmo_cnt <= '0;
      instret <= '0;
    end else begin
      cur     <= nxt;
      tmo_cnt <= tmo_nxt;
      if (retire) instret <= instret + CNT_W'(1);
    end
  end

  always_comb begin
    nxt         = cur;
    tmo_nxt     = '0;
    retire      = 1'b0;
    imem_req    = 1'b0;
    dmem_req    = 1'b0;
    dmem_we     = 1'b0;
    ir_we       = 1'b0;
    pc_we       = 1'b0;
    pc_src      = PC_PLUS4;
    alu_src_b   = 1'b0;
    alu_ctrl_op = ALU_ADD;
    imm_ctrl    = 3'd0;
    reg_we      = 1'b0;
    wb_sel      = WB_ALU;
    trap        = 1'b0;
    case (cur)
      FETCH: begin
        imem_req = 1'b1;
        if (imem_ready) begin
          ir_we  = 1'b1;
          pc_we  = 1'b1;
          pc_src = PC_PLUS4;
          nxt    = DECODE;
        end else if (tmo_hit) begin
          nxt = TRAP;
        end else begin
          tmo_nxt = tmo_cnt + 1'b1;
        end
      end
      DECODE: begin
        imm_ctrl = dec_imm;
        nxt      = (iclass == CLS_ILLEGAL) ? TRAP : EXEC;
      end
      EXEC: begin
        imm_ctrl = dec_imm;
        case (iclass)
          CLS_R: begin
            alu_ctrl_op = ALU_FUNCT;
            nxt         = WB;
          end
          CLS_I: begin
            alu_src_b   = 1'b1;
            alu_ctrl_op = ALU_FUNCT;
            nxt         = WB;
          end
          CLS_LD, CLS_ST: begin
            alu_src_b = 1'b1;
            nxt       = MEM;
          end
          CLS_LUI: begin
            alu_src_b   = 1'b1;
            alu_ctrl_op = ALU_PASSB;
            nxt         = WB;
          end
          CLS_BR: begin
            alu_ctrl_op = ALU_BR;
            pc_src      = PC_BRANCH;
            pc_we       = is_bne ? ~alu_zero : alu_zero;
            retire      = 1'b1;
            nxt         = FETCH;
          end
          CLS_JAL: begin
            pc_we  = 1'b1;
            pc_src = PC_JAL;
            reg_we = 1'b1;
            wb_sel = WB_PC4;
            retire = 1'b1;
            nxt    = FETCH;
          end
          default: nxt = TRAP;
        endcase
      end
      MEM: begin
        // address operands stay on the ALU for the whole access
        imm_ctrl  = dec_imm;
        alu_src_b = 1'b1;
        dmem_req  = 1'b1;
        dmem_we   = (iclass == CLS_ST);
        if (dmem_ready) begin
          if (iclass == CLS_ST) begin
            retire = 1'b1;
            nxt    = FETCH;
          end else begin
            nxt = WB;
          end
        end else if (tmo_hit) begin
          nxt = TRAP;
        end else begin
          tmo_nxt = tmo_cnt + 1'b1;
        end
      end
      WB: begin
        imm_ctrl = dec_imm;
        reg_we   = 1'b1;
        wb_sel   = (iclass == CLS_LD) ? WB_MEM : WB_ALU;
        retire   = 1'b1;
        nxt      = FETCH;
      end
      TRAP: begin
        trap = 1'b1;
      end
      default: nxt = FETCH;
    endcase
  end

endmodule

// File: tb/tb_mc_ctrl_unit.sv
// Directed bench for mc_ctrl_unit (CNT_W=4, TIMEOUT=4) with hand-computed
// expected control outputs per FSM cycle.
module tb_mc_ctrl_unit;

  localparam logic [31:0] I_ADD  = 32'h002081B3;
  localparam logic [31:0] I_LW   = 32'h0000A183;
  localparam logic [31:0] I_SW   = 32'h0020A023;
  localparam logic [31:0] I_BEQ  = 32'h00208063;
  localparam logic [31:0] I_BNE  = 32'h00209063;
  localparam logic [31:0] I_BLT2 = 32'h0020A063;
  localparam logic [31:0] I_JAL  = 32'h008000EF;
  localparam logic [31:0] I_LUI  = 32'h123450B7;
  localparam logic [31:0] I_ADDI = 32'h00108093;
  localparam logic [31:0] I_BAD  = 32'h0000007F;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] instr;
  logic        alu_zero, imem_ready, dmem_ready;
  logic        imem_req, dmem_req, dmem_we, ir_we, pc_we;
  logic [1:0]  pc_src, alu_ctrl_op, wb_sel;
  logic        alu_src_b, reg_we, trap;
  logic [2:0]  imm_ctrl, state;
  logic [3:0]  instret;

  int checks = 0;
  int errors = 0;

  mc_ctrl_unit #(.CNT_W(4), .TIMEOUT(4), .EN_JAL(1)) dut (
    .clk(clk), .rst_n(rst_n), .instr(instr), .alu_zero(alu_zero),
    .imem_ready(imem_ready), .dmem_ready(dmem_ready), .imem_req(imem_req),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .ir_we(ir_we), .pc_we(pc_we),
    .pc_src(pc_src), .alu_src_b(alu_src_b), .alu_ctrl_op(alu_ctrl_op),
    .imm_ctrl(imm_ctrl), .reg_we(reg_we), .wb_sel(wb_sel), .trap(trap),
    .instret(instret), .state(state)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic [31:0] i, input logic ir, input logic dr, input logic az);
    instr      = i;
    imem_ready = ir;
    dmem_ready = dr;
    alu_zero   = az;
    #1;
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    applyStimulus(32'h0, 1'b0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
  endtask

  // fetch with zero-wait memory; leaves the FSM in DECODE
  task automatic fetchDecode(input logic [31:0] i);
    applyStimulus(i, 1'b1, 1'b0, 1'b0);
    nextCycle();
    applyStimulus(i, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    rst_n = 1'b0;
    applyStimulus(32'h0, 1'b0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #2;
    checkOutput("rst_state", state, 0);
    checkOutput("rst_instret", instret, 0);
    checkOutput("rst_trap", trap, 0);
    checkOutput("rst_dmem_req", dmem_req, 0);
    rst_n = 1'b1;
    #1;

    $display("[TB] R-type add");
    applyStimulus(I_ADD, 1'b1, 1'b0, 1'b0);
    checkOutput("r_c0_imem_req", imem_req, 1);
    checkOutput("r_c0_ir_we", ir_we, 1);
    checkOutput("r_c0_pc_we", pc_we, 1);
    checkOutput("r_c0_pc_src", pc_src, 0);
    nextCycle();
    applyStimulus(I_ADD, 1'b0, 1'b0, 1'b0);
    checkOutput("r_c1_state", state, 1);
    checkOutput("r_c1_pc_we", pc_we, 0);
    nextCycle();
    checkOutput("r_c2_alu_op", alu_ctrl_op, 2);
    checkOutput("r_c2_src_b", alu_src_b, 0);
    checkOutput("r_c2_reg_we", reg_we, 0);
    nextCycle();
    checkOutput("r_c3_reg_we", reg_we, 1);
    checkOutput("r_c3_wb_sel", wb_sel, 0);
    checkOutput("r_c3_instret", instret, 0);
    nextCycle();
    checkOutput("r_done_state", state, 0);
    checkOutput("r_done_instret", instret, 1);

    $display("[TB] LW with two wait cycles");
    fetchDecode(I_LW);
    checkOutput("lw_imm", imm_ctrl, 0);
    nextCycle();
    checkOutput("lw_exec_src_b", alu_src_b, 1);
    checkOutput("lw_exec_op", alu_ctrl_op, 0);
    nextCycle();
    checkOutput("lw_mem1_req", dmem_req, 1);
    checkOutput("lw_mem1_we", dmem_we, 0);
    nextCycle();
    checkOutput("lw_mem2_req", dmem_req, 1);
    nextCycle();
    applyStimulus(I_LW, 1'b0, 1'b1, 1'b0);
    checkOutput("lw_mem3_req", dmem_req, 1);
    checkOutput("lw_mem3_reg_we", reg_we, 0);
    nextCycle();
    applyStimulus(I_LW, 1'b0, 1'b0, 1'b0);
    checkOutput("lw_wb_state", state, 4);
    checkOutput("lw_wb_reg_we", reg_we, 1);
    checkOutput("lw_wb_sel", wb_sel, 1);
    checkOutput("lw_wb_dmem_req", dmem_req, 0);
    nextCycle();
    checkOutput("lw_instret", instret, 2);

    $display("[TB] SW with two wait cycles");
    fetchDecode(I_SW);
    checkOutput("sw_imm", imm_ctrl, 1);
    nextCycle();
    nextCycle();
    checkOutput("sw_mem1_we", dmem_we, 1);
    checkOutput("sw_mem1_reg_we", reg_we, 0);
    nextCycle();
    nextCycle();
    applyStimulus(I_SW, 1'b0, 1'b1, 1'b0);
    checkOutput("sw_mem3_req", dmem_req, 1);
    checkOutput("sw_mem3_reg_we", reg_we, 0);
    nextCycle();
    applyStimulus(I_SW, 1'b0, 1'b0, 1'b0);
    checkOutput("sw_done_state", state, 0);
    checkOutput("sw_instret", instret, 3);

    $display("[TB] branches");
    fetchDecode(I_BNE);
    checkOutput("bne_imm", imm_ctrl, 2);
    nextCycle();
    checkOutput("bne_z0_pc_we", pc_we, 1);
    checkOutput("bne_z0_pc_src", pc_src, 1);
    checkOutput("bne_alu_op", alu_ctrl_op, 1);
    nextCycle();
    checkOutput("bne_state", state, 0);
    checkOutput("bne_instret", instret, 4);
    fetchDecode(I_BEQ);
    nextCycle();
    checkOutput("beq_z0_pc_we", pc_we, 0);
    nextCycle();
    checkOutput("beq_z0_instret", instret, 5);
    fetchDecode(I_BEQ);
    nextCycle();
    applyStimulus(I_BEQ, 1'b0, 1'b0, 1'b1);
    checkOutput("beq_z1_pc_we", pc_we, 1);
    nextCycle();
    checkOutput("beq_z1_instret", instret, 6);

    $display("[TB] JAL, LUI, ADDI");
    fetchDecode(I_JAL);
    checkOutput("jal_imm", imm_ctrl, 3);
    nextCycle();
    checkOutput("jal_pc_we", pc_we, 1);
    checkOutput("jal_pc_src", pc_src, 2);
    checkOutput("jal_reg_we", reg_we, 1);
    checkOutput("jal_wb_sel", wb_sel, 2);
    nextCycle();
    checkOutput("jal_instret", instret, 7);
    fetchDecode(I_LUI);
    checkOutput("lui_imm", imm_ctrl, 4);
    nextCycle();
    checkOutput("lui_alu_op", alu_ctrl_op, 3);
    nextCycle();
    checkOutput("lui_wb_reg_we", reg_we, 1);
    checkOutput("lui_wb_sel", wb_sel, 0);
    nextCycle();
    checkOutput("lui_instret", instret, 8);
    fetchDecode(I_ADDI);
    nextCycle();
    checkOutput("addi_src_b", alu_src_b, 1);
    checkOutput("addi_alu_op", alu_ctrl_op, 2);
    nextCycle();
    nextCycle();
    checkOutput("addi_instret", instret, 9);

    $display("[TB] instret wrap");
    for (int k = 0; k < 8; k++) begin
      fetchDecode(I_BEQ);
      nextCycle();
      applyStimulus(I_BEQ, 1'b0, 1'b0, 1'b1);
      nextCycle();
    end
    checkOutput("wrap_instret", instret, 1);

    $display("[TB] data memory timeout");
    fetchDecode(I_LW);
    nextCycle();
    nextCycle();
    repeat (3) nextCycle();
    checkOutput("dto_mem4_state", state, 3);
    nextCycle();
    checkOutput("dto_state", state, 5);
    checkOutput("dto_dmem_req", dmem_req, 0);
    checkOutput("dto_instret", instret, 1);

    $display("[TB] fetch timeout");
    doReset();
    checkOutput("fto_c1_state", state, 0);
    repeat (3) nextCycle();
    checkOutput("fto_c4_state", state, 0);
    checkOutput("fto_c4_ir_we", ir_we, 0);
    nextCycle();
    checkOutput("fto_c5_state", state, 5);
    checkOutput("fto_trap", trap, 1);
    checkOutput("fto_imem_req", imem_req, 0);

    doReset();
    repeat (3) nextCycle();
    applyStimulus(I_ADD, 1'b1, 1'b0, 1'b0);
    checkOutput("fready_c4_ir_we", ir_we, 1);
    nextCycle();
    checkOutput("fready_state", state, 1);

    $display("[TB] illegal instructions");
    doReset();
    fetchDecode(I_BAD);
    nextCycle();
    checkOutput("ill_state", state, 5);
    for (int k = 0; k < 20; k++) begin
      applyStimulus(I_ADD, 1'b1, 1'b1, 1'b1);
      nextCycle();
    end
    checkOutput("ill_trap_held", trap, 1);
    checkOutput("ill_state_held", state, 5);
    checkOutput("ill_instret", instret, 0);
    checkOutput("ill_imem_req", imem_req, 0);
    checkOutput("ill_pc_we", pc_we, 0);
    doReset();
    fetchDecode(I_BLT2);
    nextCycle();
    checkOutput("br010_state", state, 5);
    checkOutput("br010_trap", trap, 1);

    $display("[TB] reset during MEM");
    doReset();
    fetchDecode(I_LW);
    nextCycle();
    nextCycle();
    checkOutput("rmem_req_before", dmem_req, 1);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("rmem_req_async", dmem_req, 0);
    checkOutput("rmem_state_async", state, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
    checkOutput("rmem_state_after", state, 0);
    checkOutput("rmem_instret", instret, 0);
    fetchDecode(I_ADD);
    nextCycle();
    nextCycle();
    nextCycle();
    checkOutput("rmem_recover_instret", instret, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
